// File: rtl/flag_register_unit_if.sv
// ALU/control-unit side bundle for the condition-code register stage.
// The unit takes the slave view; the ALU/control side (or a bench) takes the master view.
interface flag_register_unit_if;
    logic       Zero;
    logic       Sign;
    logic       Overflow;
    logic       Carry;
    logic       Update;
    logic       Push;
    logic       Pop;
    logic [2:0] Cond;
    logic       Branch_take;
    logic [3:0] Flags;
    logic [7:0] Zsoc;
    logic       Condition_update;
    logic       Stack_full;
    logic       Stack_empty;
    logic       Stack_err;

    modport master (
        output Zero, Sign, Overflow, Carry, Update, Push, Pop, Cond,
        input  Branch_take, Flags, Zsoc, Condition_update,
               Stack_full, Stack_empty, Stack_err
    );

    modport slave (
        input  Zero, Sign, Overflow, Carry, Update, Push, Pop, Cond,
        output Branch_take, Flags, Zsoc, Condition_update,
               Stack_full, Stack_empty, Stack_err
    );
endinterface

// File: rtl/flag_register_unit.sv
// Condition-code register with branch evaluation and a flag save/restore stack.
// Define CCR_STACK_ERR_EN to enable the sticky Stack_err overflow/underflow flag.
module flag_register_unit #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input logic                 CCR_clk,
    input logic                 Reset,
    flag_register_unit_if.slave bus
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE      = (PTR_W+1)'(1);

    logic [3:0]       ccr;
    logic [3:0]       stack [DEPTH];
    logic [PTR_W:0]   ptr;
    logic [PTR_W:0]   ptr_dec;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] push_idx;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;
    logic             do_swap;
    logic             cond_upd;
    logic [3:0]       alu_flags;

    assign full      = (ptr == FULL_CNT);
    assign empty     = (ptr == '0);
    assign ptr_dec   = ptr - ONE;
    assign top_idx   = ptr_dec[PTR_W-1:0];
    assign push_idx  = ptr[PTR_W-1:0];
    assign alu_flags = {bus.Zero, bus.Sign, bus.Overflow, bus.Carry};

    assign do_push = bus.Push & ~bus.Pop & ~full;
    assign do_pop  = bus.Pop & ~bus.Push & ~empty;
    assign do_swap = bus.Push & bus.Pop & ~empty;

    // Pop/swap restore overrides Update; illegal ops fall through so Update still applies.
    always_ff @(posedge CCR_clk or posedge Reset) begin
        if (Reset) begin
            ccr      <= '0;
            ptr      <= '0;
            cond_upd <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            cond_upd <= do_pop | do_swap;
            if (do_pop) begin
                ccr <= stack[top_idx];
                ptr <= ptr_dec;
            end else if (do_swap) begin
                ccr            <= stack[top_idx];
                stack[top_idx] <= ccr;
            end else begin
                if (do_push) begin
                    stack[push_idx] <= ccr;
                    ptr             <= ptr + ONE;
                end
                if (bus.Update) begin
                    ccr <= alu_flags;
                end
            end
        end
    end

`ifdef CCR_STACK_ERR_EN
    logic illegal;
    logic err;

    assign illegal = (bus.Push & ~bus.Pop & full) | (bus.Pop & empty);

    always_ff @(posedge CCR_clk or posedge Reset) begin
        if (Reset) begin
            err <= 1'b0;
        end else if (illegal) begin
            err <= 1'b1;
        end
    end

    assign bus.Stack_err = err;
`else
    assign bus.Stack_err = 1'b0;
`endif

    always_comb begin
        bus.Branch_take = 1'b0;
        case (bus.Cond)
            3'b000:  bus.Branch_take = 1'b1;
            3'b001:  bus.Branch_take = ccr[3];
            3'b010:  bus.Branch_take = ~ccr[3];
            3'b011:  bus.Branch_take = ccr[2];
            3'b100:  bus.Branch_take = ~ccr[2];
            3'b101:  bus.Branch_take = ccr[0];
            3'b110:  bus.Branch_take = ccr[1];
            3'b111:  bus.Branch_take = ccr[2] ^ ccr[1];
            default: bus.Branch_take = 1'b0;
        endcase
    end

    assign bus.Flags            = ccr;
    assign bus.Zsoc             = {4'b0000, ccr};
    assign bus.Condition_update = cond_upd;
    assign bus.Stack_full       = full;
    assign bus.Stack_empty      = empty;

endmodule

// File: tb/tb_flag_register_unit.sv
// Scoreboard bench for flag_register_unit: queue-based stack model, random and directed stimulus.
// Stack_err expectations follow CCR_STACK_ERR_EN.
module tb_flag_register_unit;

    localparam int DEPTH = 4;

    typedef struct {
        logic [3:0] flags;
        logic       cu;
        logic       full;
        logic       empty;
        logic       err;
        logic       br;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    exp_t       sb[$];
    logic [3:0] m_stk[$];
    logic [3:0] m_ccr;
    logic       m_err;

    flag_register_unit_if bus ();

    flag_register_unit #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .CCR_clk (clk),
        .Reset   (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic branch_of(input logic [3:0] f, input logic [2:0] c);
        logic z, s, o, cy;
        {z, s, o, cy} = f;
        case (c)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return s;
            3'd4: return !s;
            3'd5: return cy;
            3'd6: return o;
            default: return s != o;
        endcase
    endfunction

    task automatic model_reset();
        m_ccr = 4'b0000;
        m_err = 1'b0;
        m_stk.delete();
        sb.delete();
    endtask

    task automatic mark_illegal();
`ifdef CCR_STACK_ERR_EN
        m_err = 1'b1;
`endif
    endtask

    // One clock of stimulus plus the expected post-edge state.
    task automatic step(input bit upd, input logic [3:0] f, input bit psh, input bit pp,
                        input logic [2:0] cd);
        exp_t       e;
        logic       pulse;
        logic [3:0] old;
        @(negedge clk);
        bus.Update = upd;
        {bus.Zero, bus.Sign, bus.Overflow, bus.Carry} = f;
        bus.Push = psh;
        bus.Pop  = pp;
        bus.Cond = cd;
        pulse = 1'b0;
        if (psh && pp) begin
            if (m_stk.size() > 0) begin
                old = m_stk[m_stk.size()-1];
                m_stk[m_stk.size()-1] = m_ccr;
                m_ccr = old;
                pulse = 1'b1;
            end else begin
                mark_illegal();
                if (upd) m_ccr = f;
            end
        end else if (pp) begin
            if (m_stk.size() > 0) begin
                m_ccr = m_stk.pop_back();
                pulse = 1'b1;
            end else begin
                mark_illegal();
                if (upd) m_ccr = f;
            end
        end else begin
            if (psh) begin
                if (m_stk.size() < DEPTH) m_stk.push_back(m_ccr);
                else mark_illegal();
            end
            if (upd) m_ccr = f;
        end
        e.flags = m_ccr;
        e.cu    = pulse;
        e.full  = (m_stk.size() == DEPTH);
        e.empty = (m_stk.size() == 0);
        e.err   = m_err;
        e.br    = branch_of(m_ccr, cd);
        sb.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_flags"}, {4'h0, bus.Flags}, 8'h00);
        chk({tag, "_zsoc"}, bus.Zsoc, 8'h00);
        chk({tag, "_cu"}, {7'd0, bus.Condition_update}, 8'd0);
        chk({tag, "_empty"}, {7'd0, bus.Stack_empty}, 8'd1);
        chk({tag, "_full"}, {7'd0, bus.Stack_full}, 8'd0);
        chk({tag, "_err"}, {7'd0, bus.Stack_err}, 8'd0);
    endtask

    // Monitor: every post-edge sample with a pending expectation is compared.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("flags", {4'h0, bus.Flags}, {4'h0, e.flags});
            chk("zsoc", bus.Zsoc, {4'h0, e.flags});
            chk("cond_update", {7'd0, bus.Condition_update}, {7'd0, e.cu});
            chk("full", {7'd0, bus.Stack_full}, {7'd0, e.full});
            chk("empty", {7'd0, bus.Stack_empty}, {7'd0, e.empty});
            chk("err", {7'd0, bus.Stack_err}, {7'd0, e.err});
            chk("branch", {7'd0, bus.Branch_take}, {7'd0, e.br});
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.Update = 1'b0; bus.Push = 1'b0; bus.Pop = 1'b0; bus.Cond = 3'd0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.Zero = 1'b0; bus.Sign = 1'b0; bus.Overflow = 1'b0; bus.Carry = 1'b0;
        bus.Update = 1'b0; bus.Push = 1'b0; bus.Pop = 1'b0; bus.Cond = 3'd0;
        model_reset();
        #1;
        chk_reset_outputs("por");
        do_reset();

        // Capture and branch on Z
        step(1, 4'b1001, 0, 0, 3'b001);
        step(0, 4'b0000, 0, 0, 3'b010);
        // Push+Update saves pre-update CCR, then pop restores it
        step(1, 4'b0110, 1, 0, 3'b111);
        step(0, 4'b0000, 0, 1, 3'b101);
        step(0, 4'b0000, 0, 0, 3'b110);

        // Fill to DEPTH, overflow push, drain in LIFO order
        do_reset();
        step(1, 4'd1, 0, 0, 3'd0);
        for (int i = 2; i <= 5; i++) step(1, 4'(i), 1, 0, 3'd3);
        step(0, 4'd0, 1, 0, 3'd0);
        for (int i = 0; i < 4; i++) step(0, 4'd0, 0, 1, 3'd5);
        step(0, 4'd0, 0, 0, 3'd0);

        // Pop on empty with Update: Update applies, no pulse
        step(1, 4'b1111, 0, 1, 3'b111);
        step(0, 4'b0000, 0, 0, 3'b001);

        // Swap
        do_reset();
        step(1, 4'b1100, 0, 0, 3'd0);
        step(1, 4'b0011, 1, 0, 3'd0);
        step(1, 4'b1010, 1, 1, 3'd4);
        step(0, 4'b0000, 0, 1, 3'd1);
        step(1, 4'b0101, 1, 1, 3'd2);

        // Async reset between edges with a push pending
        do_reset();
        step(1, 4'b0111, 1, 0, 3'd0);
        step(1, 4'b1110, 1, 0, 3'd0);
        @(negedge clk);
        bus.Push = 1'b1;
        bus.Update = 1'b1;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk_reset_outputs("async");
        @(posedge clk);
        #1;
        chk_reset_outputs("held");
        @(negedge clk);
        bus.Push = 1'b0; bus.Update = 1'b0;
        rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), 4'($urandom), $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, 3'($urandom));
        end

        @(negedge clk);
        bus.Update = 1'b0; bus.Push = 1'b0; bus.Pop = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drain", 8'(sb.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
